pool_frame_ctrl: RTL
====================

Name: pool_frame_ctrl

Overview:
- Frame-level sequencer placed between the Sobel output stream and the 2x2 stride-1 average-pooling datapath.
- On each start it flushes the pooling block by driving its active-low reset for a fixed number of cycles.
- It then admits exactly one IMG_W x IMG_H frame of 12-bit pixels, applying serializer backpressure, and counts the pooled pixels that come back.
- It signals completion, or an error on drain timeout.

Parameters:
- IMG_W, 62, input pixels per row; must equal the pooling row length.
- IMG_H, 62, input rows per frame.
- FLUSH_CYCLES, 4, cycles pool_reset_n is held low at frame start (>=1).
- DRAIN_TIMEOUT, 64, maximum DRAIN cycles without completing before an error is declared.

Ports:
- clk_200mhz  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to process a frame; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at end of frame.
- frame_error  out  1  set with frame_done on timeout; held until the next accepted start.
- src_pixel  in  12  pixel from Sobel.
- src_valid  in  1  src_pixel valid.
- src_ready  out  1  controller accepts the pixel.
- pool_pixel  out  12  pixel to pooling (combinational copy of src_pixel).
- pool_valid  out  1  transfer strobe to pooling.
- pool_reset_n  out  1  active-low reset to the pooling block, registered.
- pool_valid_out  in  1  pooled-pixel strobe from pooling.
- ser_ready  in  1  serializer backpressure.
- out_count  out  12  pooled pixels counted in the current frame.
- stall_cycles  out  16  see Optional Feature.

Behaviour:
- Reset values: src_ready=0, pool_valid=0, busy=0, frame_done=0, frame_error=0, pool_reset_n=0, out_count=0, stall_cycles=0, state=IDLE, col/row/timers=0.
- Reset is asynchronous and active-high. Asserting it mid-frame aborts the frame immediately with no done pulse.
- States: IDLE, FLUSH, STREAM, DRAIN, DONE.
- IDLE:
  - pool_reset_n=1.
  - On start: clear col, row, out_count, drain timer and frame_error; go to FLUSH.
- FLUSH:
  - pool_reset_n=0 for exactly FLUSH_CYCLES cycles, then STREAM.
  - pool_reset_n returns to 1 on the first STREAM cycle.
- STREAM:
  - src_ready = ser_ready (combinational).
  - pool_valid = src_valid & src_ready. A transfer is that same condition.
  - On each transfer, col increments. At IMG_W-1, col wraps to 0 and row increments.
  - The transfer at col=IMG_W-1, row=IMG_H-1 moves to DRAIN.
  - Total transfers per frame = IMG_W*IMG_H (3844 by default).
- src_ready=0 and pool_valid=0 in every state other than STREAM.
- out_count:
  - Increments on pool_valid_out, in STREAM and DRAIN only.
  - pool_valid_out in any other state is ignored.
  - Saturates at 4095.
- Expected output count EXP = (IMG_W-1)*(IMG_H-1), i.e. 3721 by default.
- DRAIN:
  - The drain timer increments every cycle.
  - If out_count (including an increment in the same cycle) reaches EXP, go to DONE with error=0.
  - Otherwise, when the timer reaches DRAIN_TIMEOUT, go to DONE with frame_error=1.
  - If both conditions hold in the same cycle, success wins.
- DONE:
  - frame_done=1 for this one cycle, then IDLE.
  - out_count holds until the next start.
- start is ignored outside IDLE, including in DONE.
- Latency:
  - start to first cycle src_ready may be high = 1 + FLUSH_CYCLES cycles.
  - Last expected pool_valid_out to frame_done = 1 cycle.

Optional Feature:
- Macro: FRAME_STATS_EN.
- When defined:
  - stall_cycles counts STREAM cycles with src_valid=1 and ser_ready=0.
  - It is cleared on accepted start, saturates at 16'hFFFF, and holds after the frame.
- When undefined: stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Reset, then start; feed 3844 pixels with src_valid=1, ser_ready=1; a pooling model returns 3721 pool_valid_out. Expect:
  - pool_reset_n low for exactly 4 cycles.
  - 3844 pool_valid pulses.
  - frame_done one cycle after the 3721st strobe.
  - frame_error=0, out_count=3721.
- Toggle ser_ready with a 50% random pattern. Expect:
  - src_ready mirrors ser_ready in STREAM.
  - No pool_valid while ser_ready=0.
  - Still exactly 3844 transfers.
  - With FRAME_STATS_EN, stall_cycles equals the number of ser_ready=0 cycles with src_valid=1.
- The pooling model withholds its last 10 outputs. Expect frame_done and frame_error=1 exactly 64 cycles after entering DRAIN, with out_count=3711.
- Pulse start during STREAM and during DONE. Expect no effect. A later start from IDLE clears frame_error and restarts at col=0, row=0.
- Assert reset after 1000 transfers. Expect:
  - All outputs at reset values in the same cycle.
  - No frame_done.
  - A following start processes a complete 3844-pixel frame normally.
- The 3721st pool_valid_out coincides with the timer reaching 64. Expect frame_done with frame_error=0.

Source files
------------

// File: rtl/pool_frame_ctrl.sv
// pool_frame_ctrl: frame-level sequencer between the Sobel stream and the 2x2
// stride-1 average-pooling datapath. Each accepted start flushes the pooling
// block, admits one IMG_W x IMG_H frame under serializer backpressure, counts
// the pooled pixels returned and ends with a done pulse (error on drain timeout).
//
// Ports:
//   clk_200mhz, reset      : single clock, asynchronous active-high reset
//   start                  : one-cycle frame request, honoured only while idle
//   busy                   : high whenever a frame is in progress (not IDLE)
//   frame_done/frame_error : end-of-frame pulse; error flag held until next start
//   src_pixel/src_valid/src_ready : Sobel input stream
//   pool_pixel/pool_valid  : pixel stream to pooling (pixel is a straight copy)
//   pool_reset_n           : registered active-low reset to pooling block
//   pool_valid_out         : pooled-pixel strobe returned by pooling
//   ser_ready              : serializer backpressure
//   out_count              : pooled pixels counted this frame (saturating)
//   stall_cycles           : backpressure stall counter
//
// Build option: define FRAME_STATS_EN to build the stall_cycles counter;
// otherwise stall_cycles is tied to zero.
module pool_frame_ctrl #(
    parameter int IMG_W         = 62,
    parameter int IMG_H         = 62,
    parameter int FLUSH_CYCLES  = 4,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic        clk_200mhz,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_error,
    input  logic [11:0] src_pixel,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [11:0] pool_pixel,
    output logic        pool_valid,
    output logic        pool_reset_n,
    input  logic        pool_valid_out,
    input  logic        ser_ready,
    output logic [11:0] out_count,
    output logic [15:0] stall_cycles
);

    localparam logic [15:0] COL_LAST   = 16'(IMG_W - 1);
    localparam logic [15:0] ROW_LAST   = 16'(IMG_H - 1);
    localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TIMEOUT    = 16'(DRAIN_TIMEOUT);
    // A 2x2 stride-1 window yields one output per input pixel with row>0, col>0.
    localparam logic [11:0] EXP_CNT    = 12'((IMG_W - 1) * (IMG_H - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [15:0] r_col;
    logic [15:0] r_row;
    logic [15:0] r_timer;      // flush length in FLUSH, drain age in DRAIN
    logic [11:0] r_out_count;
    logic        r_busy;
    logic        r_frame_done;
    logic        r_frame_error;
    logic        r_pool_reset_n;

    logic        w_stream;
    logic        w_xfer;
    logic        w_last_xfer;
    logic        w_cnt_inc;
    logic [11:0] w_cnt_next;
    logic [15:0] w_timer_next;

    assign w_stream     = (r_state == S_STREAM);
    assign w_xfer       = w_stream & src_valid & ser_ready;
    assign w_last_xfer  = w_xfer && (r_col == COL_LAST) && (r_row == ROW_LAST);
    // Pooled strobes only count while pixels can still be in flight.
    assign w_cnt_inc    = pool_valid_out
                          && ((r_state == S_STREAM) || (r_state == S_DRAIN))
                          && (r_out_count != 12'hFFF);
    assign w_cnt_next   = r_out_count + 12'(w_cnt_inc);
    assign w_timer_next = r_timer + 16'd1;

    // Ready is a combinational pass-through of the serializer so a stalled
    // serializer never lets a pixel slip into the pooling block.
    assign src_ready    = w_stream & ser_ready;
    assign pool_valid   = w_xfer;
    assign pool_pixel   = src_pixel;

    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign frame_error  = r_frame_error;
    assign pool_reset_n = r_pool_reset_n;
    assign out_count    = r_out_count;

    always_ff @(posedge clk_200mhz or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_col          <= 16'd0;
            r_row          <= 16'd0;
            r_timer        <= 16'd0;
            r_out_count    <= 12'd0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
            r_frame_error  <= 1'b0;
            r_pool_reset_n <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_out_count  <= w_cnt_next;
            case (r_state)
                S_IDLE: begin
                    r_pool_reset_n <= 1'b1;
                    r_busy         <= 1'b0;
                    if (start) begin
                        r_col          <= 16'd0;
                        r_row          <= 16'd0;
                        r_timer        <= 16'd0;
                        r_out_count    <= 12'd0;
                        r_frame_error  <= 1'b0;
                        r_pool_reset_n <= 1'b0;
                        r_busy         <= 1'b1;
                        r_state        <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (r_timer == FLUSH_LAST) begin
                        r_timer        <= 16'd0;
                        r_pool_reset_n <= 1'b1;
                        r_state        <= S_STREAM;
                    end else begin
                        r_timer <= w_timer_next;
                    end
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        if (r_col == COL_LAST) begin
                            r_col <= 16'd0;
                            r_row <= r_row + 16'd1;
                        end else begin
                            r_col <= r_col + 16'd1;
                        end
                    end
                    if (w_last_xfer) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_timer <= w_timer_next;
                    // Completion is checked first so a final strobe landing on
                    // the timeout cycle still reports success.
                    if (w_cnt_next >= EXP_CNT) begin
                        r_frame_done  <= 1'b1;
                        r_frame_error <= 1'b0;
                        r_state       <= S_DONE;
                    end else if (w_timer_next >= TIMEOUT) begin
                        r_frame_done  <= 1'b1;
                        r_frame_error <= 1'b1;
                        r_state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FRAME_STATS_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk_200mhz or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= 16'd0;
        end else if ((r_state == S_IDLE) && start) begin
            r_stall_cycles <= 16'd0;
        end else if (w_stream && src_valid && !ser_ready
                     && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 16'd0;
`endif

endmodule
